// File: rtl/icache_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_if
// Description : Fetch-side and refill-side signal bundle of icache_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_fetch_if;
    logic [31:0] pc_in;
    logic        flush;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    // master: CPU plus instruction memory; slave: the cache itself
    modport master (
        output pc_in, flush, mem_rdata, mem_ack,
        input  inst_out, inst_valid, stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );
    modport slave (
        input  pc_in, flush, mem_rdata, mem_ack,
        output inst_out, inst_valid, stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch
// Description : Direct-mapped one-word-per-line instruction cache, blocking refill.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch #(
    parameter int LINES = 16
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave bus
);
    localparam int          IW  = $clog2(LINES);
    localparam int          TW  = 30 - IW;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TW-1:0]     tag_q  [LINES];
    logic [31:0]       data_q [LINES];
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              discard_q, discard_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic              wr_en;
    logic              hit;
    logic [IW-1:0]     idx, rf_idx;
    logic [TW-1:0]     tag, rf_tag;
    logic              out_valid, out_stall, out_req;
    logic [31:0]       out_inst;
    logic              unused_pc_lsbs;

    assign idx            = bus.pc_in[2+IW-1:2];
    assign tag            = bus.pc_in[31:2+IW];
    assign rf_idx         = mem_addr_q[2+IW-1:2];
    assign rf_tag         = mem_addr_q[31:2+IW];
    assign unused_pc_lsbs = ^bus.pc_in[1:0];

    assign hit = (state_q == IDLE) && !bus.flush && valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wr_en      = 1'b0;
        out_valid  = 1'b0;
        out_inst   = NOP;
        out_stall  = 1'b1;
        out_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    out_valid = 1'b1;
                    out_inst  = data_q[idx];
                    out_stall = 1'b0;
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                end else if (bus.flush) begin
                    valid_d = '0;
                end else begin
                    state_d    = REFILL;
                    mem_addr_d = {bus.pc_in[31:2], 2'b00};
                    discard_d  = 1'b0;
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                end
            end
            REFILL: begin
                out_req = 1'b1;
                if (bus.flush) valid_d = '0;
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    // A flush in this very cycle discards the data as well
                    if (!bus.flush && !discard_q) begin
                        wr_en           = 1'b1;
                        valid_d[rf_idx] = 1'b1;
                    end
                end else if (bus.flush) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            data_q[rf_idx] <= bus.mem_rdata;
            tag_q[rf_idx]  <= rf_tag;
        end
    end

    assign bus.inst_out   = out_inst;
    assign bus.inst_valid = out_valid;
    assign bus.stall      = out_stall;
    assign bus.mem_req    = out_req;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch
// Description : Scoreboarded random and directed bench for icache_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch;
    localparam int          LINES = 16;
    localparam int          IW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_fetch_if bus ();
    icache_fetch #(.LINES(LINES)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct packed {
        logic        iv;
        logic [31:0] io;
        logic        st;
        logic        mr;
        logic [31:0] ma;
        logic [15:0] hc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: a table of lines plus one outstanding-refill record
    bit          m_init = 0, m_busy = 0, m_discard = 0;
    logic [31:0] m_addr = 0;
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    int          m_hit = 0, m_miss = 0;
    int          wait_left = 0;
    int          fixed_delay = -1;
    bit          ov_en = 0;
    logic [31:0] ov_data = 0;
    bit          last_hit = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic step(input logic [31:0] pc, input bit fl = 0, input bit rs = 1, input bit stray = 0);
        logic        ack;
        logic [31:0] rd, tg;
        int          idx;
        bit          hit;
        exp_t        e;
        ack = 1'b0;
        rd  = $urandom;
        if (m_busy) begin
            if (wait_left == 0) begin
                ack = 1'b1;
                rd  = ov_en ? ov_data : memval(m_addr);
            end else begin
                wait_left--;
            end
        end else if (stray) begin
            ack = 1'b1;
        end
        bus.pc_in     = pc;
        bus.flush     = fl;
        bus.mem_ack   = ack;
        bus.mem_rdata = rd;
        rst           = rs;
        idx = int'((pc >> 2) % LINES);
        tg  = pc >> (2 + IW);
        hit = !m_busy && !fl && m_valid[idx] && (m_tag[idx] == tg);
        last_hit = hit;
        e.iv = hit;
        e.io = hit ? m_data[idx] : NOP;
        e.st = !hit;
        e.mr = m_busy;
        e.ma = m_addr;
        e.hc = 16'(m_hit);
        e.mc = 16'(m_miss);
        if (m_init) sb.push_back(e);
        @(posedge clk);
        if (!rs) begin
            m_init = 1; m_busy = 0; m_discard = 0; m_addr = 0; m_hit = 0; m_miss = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
        end else if (!m_busy) begin
            if (hit) begin
                if (m_hit < 65535) m_hit++;
            end else if (fl) begin
                foreach (m_valid[i]) m_valid[i] = 0;
            end else begin
                m_busy = 1; m_discard = 0; m_addr = pc & ~32'h3;
                if (m_miss < 65535) m_miss++;
                wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
            end
        end else begin
            if (fl) foreach (m_valid[i]) m_valid[i] = 0;
            if (ack) begin
                if (!fl && !m_discard) begin
                    idx = int'((m_addr >> 2) % LINES);
                    m_valid[idx] = 1;
                    m_tag[idx]   = m_addr >> (2 + IW);
                    m_data[idx]  = rd;
                end
                m_busy = 0; m_discard = 0;
            end else if (fl) begin
                m_discard = 1;
            end
        end
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        int n;
        n = 0;
        do begin
            step(pc);
            n++;
        end while (!last_hit && n < 40);
        n_cmp++;
        if (!last_hit) begin
            n_err++;
            $display("FAIL fetch_timeout: pc %h got no hit within 40 cycles required a hit", pc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = {bus.inst_valid, bus.inst_out, bus.stall, bus.mem_req, bus.mem_addr,
                 bus.hit_cnt, bus.miss_cnt};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t: got iv=%b inst=%h stall=%b req=%b addr=%h hit=%h miss=%h required iv=%b inst=%h stall=%b req=%b addr=%h hit=%h miss=%h",
                         $time, g.iv, g.io, g.st, g.mr, g.ma, g.hc, g.mc,
                         e.iv, e.io, e.st, e.mr, e.ma, e.hc, e.mc);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        int          guard;
        bus.pc_in = 0; bus.flush = 0; bus.mem_ack = 0; bus.mem_rdata = 0;

        step(0, 0, 0);
        step(32'h1234, 0, 0);
        chk("reset_hit_cnt", {16'h0, bus.hit_cnt}, 0);
        chk("reset_miss_cnt", {16'h0, bus.miss_cnt}, 0);

        // Cold miss with a fixed three-cycle ack delay
        fixed_delay = 3;
        fetch(32'h0);
        chk("cold_miss_cnt", {16'h0, bus.miss_cnt}, 1);
        chk("cold_hit_cnt", {16'h0, bus.hit_cnt}, 1);

        fetch(32'h4); fetch(32'h8); fetch(32'hC);
        step(32'h0); step(32'h4); step(32'h8); step(32'hC);
        chk("stream_hit_cnt", {16'h0, bus.hit_cnt}, 8);
        chk("stream_miss_cnt", {16'h0, bus.miss_cnt}, 4);

        // Same index, different tag
        fetch(32'h40);
        fetch(32'h0);
        chk("conflict_miss_cnt", {16'h0, bus.miss_cnt}, 6);

        // Flush in IDLE, then flush during a refill whose data must be dropped
        step(32'h0, 1);
        step(32'h8);
        step(32'h8, 1);
        ov_en = 1; ov_data = 32'hDEAD_BEEF;
        guard = 0;
        while (m_busy && guard < 20) begin step(32'h8); guard++; end
        ov_en = 0;
        fetch(32'h8);
        fetch(32'h0);
        chk("flush_miss_cnt", {16'h0, bus.miss_cnt}, 9);

        // Flush and ack in the same cycle
        fixed_delay = 1;
        step(32'h1C); step(32'h1C); step(32'h1C, 1);
        fetch(32'h1C);
        chk("flush_ack_miss_cnt", {16'h0, bus.miss_cnt}, 11);

        // Reset while a refill is outstanding, then a stray ack
        fixed_delay = 3;
        step(32'h100); step(32'h200);
        step(32'h0, 0, 0);
        chk("midreset_hit_cnt", {16'h0, bus.hit_cnt}, 0);
        chk("midreset_miss_cnt", {16'h0, bus.miss_cnt}, 0);
        chk("midreset_mem_req", {31'h0, bus.mem_req}, 0);
        step(32'h0, 0, 1, 1);
        step(32'h0, 0, 1, 1);

        // Randomized traffic
        fixed_delay = -1;
        step(0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pc = pc | 32'h8000_0000;
            step(pc, $urandom_range(0, 99) < 3, $urandom_range(0, 99) >= 1,
                 $urandom_range(0, 9) == 0);
        end

        // Hit counter saturation
        step(0, 0, 0);
        fixed_delay = 0;
        fetch(32'h20);
        repeat (65600) step(32'h20);
        chk("sat_hit_cnt", {16'h0, bus.hit_cnt}, 32'h0000_FFFF);
        chk("sat_miss_cnt", {16'h0, bus.miss_cnt}, 1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
